bcd_serial_add_ctrl: RTL and testbench
======================================

# bcd_serial_add_ctrl

Digit-serial BCD adder controller: accepts two DIGITS-wide packed-BCD operands over a valid/ready handshake and sequences a single `bcd_fadd` one-digit adder across all digits, least significant first, one digit per clock. It then presents the registered sum and carry-out over a valid/ready handshake. It replaces the fully unrolled ripple adder wherever area matters more than latency.

## Interface
- `DIGITS`, default 100: number of BCD digits per operand. Must be ≥ 2.
- `clk`  in  1  sole clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  controller can accept operands.
- `a`  in  4*DIGITS  operand A, digit i at [4i+3:4i].
- `b`  in  4*DIGITS  operand B, same packing as `a`.
- `cin`  in  1  carry into digit 0.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `sum`  out  4*DIGITS  BCD sum, same packing as `a`.
- `cout`  out  1  carry out of digit DIGITS-1.
- `err`  out  1  invalid-digit flag (see Configuration).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch `a` and `b` into shift registers, latch `cin` into the carry register, clear the digit counter and `err`, then go to RUN.
- RUN:
  - Each cycle, `bcd_fadd` adds the low digit of each operand register plus the carry register.
  - Its digit result shifts into the top of the sum register; the sum register shifts right by 4.
  - Both operand registers shift right by 4. The carry register takes `bcd_fadd` cout.
  - The counter increments. When it reaches DIGITS-1, go to DONE at the same edge.
- DONE:
  - `out_valid`=1. `sum`, `cout` and `err` are held stable.
  - On `out_valid`&&`out_ready`: go to IDLE.
- `cout` is the carry register. It is meaningful only while `out_valid`=1.
- Counter width is $clog2(DIGITS). The counter never wraps during a transaction.
- Inputs are ignored outside IDLE, and `in_ready`=0 outside IDLE.
- An operand digit > 9 produces an unspecified digit result. The FSM still completes normally.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `sum`=0, `cout`=0, `err`=0, counter 0, operand registers 0.
- Latency: `out_valid` rises exactly DIGITS clock edges after the accepting edge. Digit i is processed at edge i+1 after acceptance.
- Throughput: one transaction per DIGITS+2 cycles at best (accept, DIGITS RUN cycles, one DONE cycle).
- The accepting edge in DONE moves the FSM to IDLE. `in_ready` rises the next cycle. There is no same-cycle DONE→accept overlap.
- Backpressure: while `out_ready`=0, DONE holds indefinitely with all outputs unchanged.
- Reset asserted mid-RUN or mid-DONE: immediate asynchronous return to reset values. The in-flight result is discarded.

## Configuration
- `BCD_SERIAL_DIGIT_CHECK_EN` defined:
  - `err` is sticky per transaction.
  - It is set in any RUN cycle where the current `a` or `b` digit is > 9.
  - It is cleared on accept and is valid with `out_valid`.
- `BCD_SERIAL_DIGIT_CHECK_EN` undefined: `err` is tied to 0 and no check logic is synthesized.

## Structure
- Package `bcd_pkg`:
  - `DIGIT_W`=4.
  - The state enum typedef (IDLE/RUN/DONE).
  - `bcd_digit_t` (logic [3:0]).
- Sub-module: one instance of `bcd_fadd`.
  - Ports a[3:0], b[3:0], cin → sum[3:0], cout.
  - Its sum is the decimal digit (a+b+cin) mod 10; cout=1 when a+b+cin ≥ 10.
- All sequencing, counter, shift registers and the check live in `bcd_serial_add_ctrl`.

## Test plan
- DIGITS=4, a=0x1234, b=0x5678, cin=1 → `sum`=0x6913, `cout`=0, `err`=0. `out_valid` rises 4 edges after accept.
- DIGITS=4, a=0x9999, b=0x0001, cin=0 → `sum`=0x0000, `cout`=1.
- DIGITS=100, a=all 9s, b=0, cin=1 → `sum`=0, `cout`=1. `out_valid` rises exactly 100 edges after accept.
- DIGITS=4, hold `out_ready`=0 for 5 cycles in DONE → `sum`/`cout` are stable and `in_ready`=0. `in_valid` pulses are ignored. After `out_ready`=1, `in_ready`=1 on the next cycle.
- DIGITS=4, deassert `resetn` at RUN digit 2 → all outputs go to reset values immediately. A new transaction (0x0005+0x0005, cin=0) then gives `sum`=0x0010, `cout`=0.
- DIGITS=4, a=0x00A0, b=0 → `err`=1 with `BCD_SERIAL_DIGIT_CHECK_EN` defined, `err`=0 without it. In both cases `out_valid` arrives after 4 edges.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder.
package bcd_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/bcd_fadd.sv
// One-digit BCD full adder: sum = (a+b+cin) mod 10, cout when a+b+cin >= 10.
module bcd_fadd
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t sum,
    output logic       cout
);

    logic [DIGIT_W:0] raw;

    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
        cout = (raw >= 5'd10);
        sum  = cout ? DIGIT_W'(raw - 5'd10) : raw[DIGIT_W-1:0];
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder controller sequencing one bcd_fadd over DIGITS digits.
// Optional invalid-digit check enabled by defining BCD_SERIAL_DIGIT_CHECK_EN.
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 100
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIGIT_W*DIGITS-1:0] a,
    input  logic [DIGIT_W*DIGITS-1:0] b,
    input  logic                      cin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIGIT_W*DIGITS-1:0] sum,
    output logic                      cout,
    output logic                      err
);

    localparam int W     = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(DIGITS);

    state_t           state;
    logic [W-1:0]     a_sr;
    logic [W-1:0]     b_sr;
    logic [CNT_W-1:0] cnt;
    bcd_digit_t       dig_sum;
    logic             dig_cout;

    bcd_fadd u_fadd (
        .a    (a_sr[DIGIT_W-1:0]),
        .b    (b_sr[DIGIT_W-1:0]),
        .cin  (cout),
        .sum  (dig_sum),
        .cout (dig_cout)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_sr      <= '0;
            b_sr      <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            cnt       <= '0;
`ifdef BCD_SERIAL_DIGIT_CHECK_EN
            err       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        cout     <= cin;
                        cnt      <= '0;
`ifdef BCD_SERIAL_DIGIT_CHECK_EN
                        err      <= 1'b0;
`endif
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sr <= {{DIGIT_W{1'b0}}, a_sr[W-1:DIGIT_W]};
                    b_sr <= {{DIGIT_W{1'b0}}, b_sr[W-1:DIGIT_W]};
                    sum  <= {dig_sum, sum[W-1:DIGIT_W]};
                    cout <= dig_cout;
`ifdef BCD_SERIAL_DIGIT_CHECK_EN
                    if (a_sr[DIGIT_W-1:0] > 4'd9 || b_sr[DIGIT_W-1:0] > 4'd9)
                        err <= 1'b1;
`endif
                    // Counter parks at DIGITS-1 on the last digit so it never wraps.
                    if (cnt == CNT_W'(DIGITS - 1)) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef BCD_SERIAL_DIGIT_CHECK_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl (4-digit and 100-digit instances).
module tb_bcd_serial_add_ctrl;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    // 4-digit instance
    logic        in_valid = 1'b0, in_ready, cin = 1'b0;
    logic        out_valid, out_ready = 1'b0, cout, err;
    logic [15:0] a = '0, b = '0, sum;

    // 100-digit instance
    logic         in_valid_w = 1'b0, in_ready_w, cin_w = 1'b0;
    logic         out_valid_w, out_ready_w = 1'b0, cout_w, err_w;
    logic [399:0] a_w = '0, b_w = '0, sum_w;

    int pass_cnt = 0;
    int total_cnt = 0;

    bcd_serial_add_ctrl #(.DIGITS(4)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .err(err)
    );

    bcd_serial_add_ctrl #(.DIGITS(100)) dut_w (
        .clk(clk), .resetn(resetn), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .a(a_w), .b(b_w), .cin(cin_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
        .sum(sum_w), .cout(cout_w), .err(err_w)
    );

    function automatic logic [15:0] to_bcd(input int unsigned v);
        logic [15:0] r;
        int unsigned x;
        x = v;
        r = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Accepts one operand pair, returns the result and edges from accept to out_valid
    // (-1 on timeout); leaves the DUT in DONE with out_ready low.
    task automatic txn4(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                        output logic [15:0] s, output logic c, output logic e, output int lat);
        @(negedge clk);
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        s = sum; c = cout; e = err;
    endtask

    task automatic release4();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #12;
        total_cnt++;
        if ({in_ready, out_valid, cout, err} !== 4'b1000 || sum !== 16'h0) begin
            $display("FAIL reset4: got rdy=%b vld=%b cout=%b err=%b sum=%h, want 1 0 0 0 0000",
                     in_ready, out_valid, cout, err, sum);
        end else pass_cnt++;
        total_cnt++;
        if ({in_ready_w, out_valid_w, cout_w, err_w} !== 4'b1000 || sum_w !== '0) begin
            $display("FAIL reset100: got rdy=%b vld=%b cout=%b err=%b",
                     in_ready_w, out_valid_w, cout_w, err_w);
        end else pass_cnt++;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_directed();
        logic [15:0] s; logic c, e; int lat;
        txn4(16'h1234, 16'h5678, 1'b1, s, c, e, lat);
        total_cnt++;
        if ({s, c, e} !== {16'h6913, 1'b0, 1'b0}) begin
            $display("FAIL dir1: got sum=%h cout=%b err=%b, want 6913 0 0", s, c, e);
        end else pass_cnt++;
        total_cnt++;
        if (lat !== 4) $display("FAIL dir1_latency: got %0d, want 4", lat);
        else pass_cnt++;
        release4();
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL dir1_release: got rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end else pass_cnt++;

        txn4(16'h9999, 16'h0001, 1'b0, s, c, e, lat);
        total_cnt++;
        if ({s, c} !== {16'h0000, 1'b1}) begin
            $display("FAIL dir2: got sum=%h cout=%b, want 0000 1", s, c);
        end else pass_cnt++;
        release4();
    endtask

    task automatic test_random();
        int unsigned av, bv, cv, tot;
        logic [15:0] s, exp_s; logic c, e, exp_c; int lat;
        for (int n = 0; n < 12; n++) begin
            av = $urandom_range(0, 9999);
            bv = $urandom_range(0, 9999);
            cv = $urandom_range(0, 1);
            tot = av + bv + cv;
            exp_s = to_bcd(tot % 10000);
            exp_c = (tot >= 10000);
            txn4(to_bcd(av), to_bcd(bv), cv[0], s, c, e, lat);
            total_cnt++;
            if (s !== exp_s || c !== exp_c || e !== 1'b0 || lat !== 4) begin
                $display("FAIL rand%0d: %0d+%0d+%0d got sum=%h cout=%b err=%b lat=%0d, want %h %b 0 4",
                         n, av, bv, cv, s, c, e, lat, exp_s, exp_c);
            end else pass_cnt++;
            release4();
        end
    endtask

    task automatic test_wide();
        int lat;
        @(negedge clk);
        for (int unsigned i = 0; i < 100; i++) a_w[4*i +: 4] = 4'h9;
        b_w = '0; cin_w = 1'b1; in_valid_w = 1'b1;
        @(posedge clk); #1;
        in_valid_w = 1'b0;
        lat = -1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (out_valid_w) begin
                lat = i;
                break;
            end
        end
        total_cnt++;
        if (lat !== 100) $display("FAIL wide_latency: got %0d, want 100", lat);
        else pass_cnt++;
        total_cnt++;
        if (sum_w !== '0 || cout_w !== 1'b1) begin
            $display("FAIL wide_sum: got nonzero=%b cout=%b, want 0 1", |sum_w, cout_w);
        end else pass_cnt++;
        @(negedge clk);
        out_ready_w = 1'b1;
        @(posedge clk); #1;
        out_ready_w = 1'b0;
        total_cnt++;
        if (in_ready_w !== 1'b1 || out_valid_w !== 1'b0) begin
            $display("FAIL wide_release: got rdy=%b vld=%b, want 1 0", in_ready_w, out_valid_w);
        end else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [15:0] s; logic c, e; int lat;
        int bad;
        txn4(16'h4567, 16'h5678, 1'b0, s, c, e, lat);
        total_cnt++;
        if (s !== 16'h0245 || c !== 1'b1) begin
            $display("FAIL bp_result: got sum=%h cout=%b, want 0245 1", s, c);
        end else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = i[0]; a = 16'h1111; b = 16'h2222; cin = 1'b1;
            @(posedge clk); #1;
            if (sum !== 16'h0245 || cout !== 1'b1 || out_valid !== 1'b1 || in_ready !== 1'b0)
                bad++;
        end
        in_valid = 1'b0;
        total_cnt++;
        if (bad !== 0) $display("FAIL bp_hold: got %0d unstable cycles, want 0", bad);
        else pass_cnt++;
        release4();
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL bp_release: got in_ready=%b, want 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_midrun_reset();
        logic [15:0] s; logic c, e; int lat;
        @(negedge clk);
        a = 16'h9876; b = 16'h5432; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        total_cnt++;
        if ({in_ready, out_valid, cout, err} !== 4'b1000 || sum !== 16'h0) begin
            $display("FAIL midrun_reset: got rdy=%b vld=%b cout=%b err=%b sum=%h, want 1 0 0 0 0000",
                     in_ready, out_valid, cout, err, sum);
        end else pass_cnt++;
        @(negedge clk);
        resetn = 1'b1;
        txn4(16'h0005, 16'h0005, 1'b0, s, c, e, lat);
        total_cnt++;
        if (s !== 16'h0010 || c !== 1'b0 || lat !== 4) begin
            $display("FAIL after_reset: got sum=%h cout=%b lat=%0d, want 0010 0 4", s, c, lat);
        end else pass_cnt++;
        release4();
    endtask

    task automatic test_err();
        logic [15:0] s; logic c, e, exp_e; int lat;
`ifdef BCD_SERIAL_DIGIT_CHECK_EN
        exp_e = 1'b1;
`else
        exp_e = 1'b0;
`endif
        txn4(16'h00A0, 16'h0000, 1'b0, s, c, e, lat);
        total_cnt++;
        if (e !== exp_e || lat !== 4) begin
            $display("FAIL err_flag: got err=%b lat=%0d, want %b 4", e, lat, exp_e);
        end else pass_cnt++;
        release4();
        txn4(16'h0321, 16'h0123, 1'b0, s, c, e, lat);
        total_cnt++;
        if (e !== 1'b0 || s !== 16'h0444) begin
            $display("FAIL err_clear: got err=%b sum=%h, want 0 0444", e, s);
        end else pass_cnt++;
        release4();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_wide();
        test_backpressure();
        test_midrun_reset();
        test_err();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
